alu_muldiv: RTL and testbench

Parametrised iterative multiply/divide unit executing MIPS32 MULT, MULTU, DIV and DIVU at configurable operand width. Sits beside the single-cycle ALU in the execute stage. Accepts one operation through a valid/ready handshake and iterates one bit per cycle. Returns a 2×WIDTH HI/LO result through a second valid/ready handshake, and can be cancelled by a pipeline flush.

---
 rtl/alu_muldiv_pkg.sv | 26 ++
 rtl/alu_muldiv_step.sv | 38 +++
 rtl/alu_muldiv.sv | 130 +++++++++++++
 tb/tb_alu_muldiv.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/alu_muldiv_pkg.sv
// Shared definitions for the iterative MIPS32 multiply/divide unit:
// op encodings, FSM state enum and op decode helpers.
package alu_muldiv_pkg;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PREP  = 3'd1,
    ST_CALC  = 3'd2,
    ST_FIXUP = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  function automatic logic op_is_unsigned(input logic [1:0] op);
    return op[0];
  endfunction

  function automatic logic op_is_div(input logic [1:0] op);
    return op[1];
  endfunction

endpackage

// File: rtl/alu_muldiv_step.sv
// One iteration of the multiply/divide datapath on unsigned magnitudes.
// Multiply is MSB-first shift-add; divide is restoring, one quotient bit per step.
module alu_muldiv_step
  import alu_muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   operand,
  input  logic               a_bit,
  input  logic               div_mode,
  output logic [2*WIDTH-1:0] acc_next,
  output logic               q_bit
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  always_comb begin
    acc_next = '0;
    q_bit    = 1'b0;
    // Partial remainder lives in acc[WIDTH-1:0]; it never reaches the divisor.
    shifted  = {acc[WIDTH-1:0], a_bit};
    diff     = shifted - {1'b0, operand};
    if (div_mode) begin
      if (shifted >= {1'b0, operand}) begin
        q_bit    = 1'b1;
        acc_next = {{(WIDTH-1){1'b0}}, diff};
      end else begin
        acc_next = {{(WIDTH-1){1'b0}}, shifted};
      end
    end else begin
      acc_next = {acc[2*WIDTH-2:0], 1'b0}
               + (a_bit ? {{WIDTH{1'b0}}, operand} : {(2*WIDTH){1'b0}});
    end
  end

endmodule

// File: rtl/alu_muldiv.sv
// Iterative MULT/MULTU/DIV/DIVU unit: valid/ready request in, WIDTH+2 cycle
// fixed latency, valid/ready HI/LO response out, cancellable by flush.
module alu_muldiv
  import alu_muldiv_pkg::*;
#(
  parameter  int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out,
  output logic             busy
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; ready/valid decode from state_q only, and flush blocks both.
  state_t               state_q, state_d;
  logic [1:0]           op_q;
  logic [WIDTH-1:0]     a_q, b_q, mag_a, mag_b, hi_q, lo_q;
  logic [2*WIDTH-1:0]   acc, acc_next;
  logic [CNT_W-1:0]     cnt;
  logic                 neg_res, neg_rem, div_zero, q_bit;
  logic                 a_neg, b_neg;
  logic [WIDTH-1:0]     fix_hi, fix_lo;

  assign a_neg = !op_is_unsigned(op_q) && a_q[WIDTH-1];
  assign b_neg = !op_is_unsigned(op_q) && b_q[WIDTH-1];

  alu_muldiv_step #(.WIDTH(WIDTH)) u_step (
    .acc      (acc),
    .operand  (mag_b),
    .a_bit    (mag_a[WIDTH-1]),
    .div_mode (op_is_div(op_q)),
    .acc_next (acc_next),
    .q_bit    (q_bit)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (req_valid) state_d = ST_PREP;
      ST_PREP:  state_d = ST_CALC;
      ST_CALC:  if (cnt == CNT_W'(1)) state_d = ST_FIXUP;
      ST_FIXUP: state_d = ST_DONE;
      ST_DONE:  if (resp_ready) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    if (flush) state_d = ST_IDLE;
  end

  // Sign correction; the most-negative/-1 divide falls out naturally as 2^(W-1).
  always_comb begin
    fix_hi = acc[2*WIDTH-1:WIDTH];
    fix_lo = acc[WIDTH-1:0];
    if (div_zero) begin
      fix_hi = a_q;
      fix_lo = '1;
    end else if (op_is_div(op_q)) begin
      fix_lo = neg_res ? -mag_a : mag_a;
      fix_hi = neg_rem ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    end else if (neg_res) begin
      {fix_hi, fix_lo} = -acc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      mag_a    <= '0;
      mag_b    <= '0;
      acc      <= '0;
      cnt      <= '0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      div_zero <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        ST_IDLE: begin
          if (req_valid && !flush) begin
            op_q <= op;
            a_q  <= a_in;
            b_q  <= b_in;
          end
        end
        ST_PREP: begin
          mag_a    <= a_neg ? -a_q : a_q;
          mag_b    <= b_neg ? -b_q : b_q;
          neg_res  <= a_neg ^ b_neg;
          neg_rem  <= op_is_div(op_q) && a_neg;
          div_zero <= op_is_div(op_q) && (b_q == '0);
          acc      <= '0;
          cnt      <= CNT_W'(WIDTH);
        end
        ST_CALC: begin
          // Dividend bits leave at the top while quotient bits enter at the bottom.
          acc   <= acc_next;
          mag_a <= {mag_a[WIDTH-2:0], q_bit};
          cnt   <= cnt - CNT_W'(1);
        end
        ST_FIXUP: begin
          hi_q <= fix_hi;
          lo_q <= fix_lo;
        end
        default: ;
      endcase
    end
  end

  assign req_ready  = (state_q == ST_IDLE);
  assign resp_valid = (state_q == ST_DONE);
  assign busy       = (state_q != ST_IDLE);
  assign hi_out     = hi_q;
  assign lo_out     = lo_q;

endmodule

// File: tb/tb_alu_muldiv.sv
// Directed bench for alu_muldiv: WIDTH=32 and WIDTH=8 instances sharing
// clock, reset and flush; expected values are hand-computed constants.
module tb_alu_muldiv;
  import alu_muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;

  logic        req_valid = 1'b0, req_ready, resp_valid, resp_ready = 1'b0, busy;
  logic [1:0]  op = 2'b00;
  logic [31:0] a_in = '0, b_in = '0, hi_out, lo_out;

  logic        req_valid_8 = 1'b0, req_ready_8, resp_valid_8, resp_ready_8 = 1'b0, busy_8;
  logic [1:0]  op_8 = 2'b00;
  logic [7:0]  a_in_8 = '0, b_in_8 = '0, hi_out_8, lo_out_8;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_muldiv #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready), .op(op),
    .a_in(a_in), .b_in(b_in),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .hi_out(hi_out), .lo_out(lo_out), .busy(busy)
  );

  alu_muldiv #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .flush(flush),
    .req_valid(req_valid_8), .req_ready(req_ready_8), .op(op_8),
    .a_in(a_in_8), .b_in(b_in_8),
    .resp_valid(resp_valid_8), .resp_ready(resp_ready_8),
    .hi_out(hi_out_8), .lo_out(lo_out_8), .busy(busy_8)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Entered and left at a falling edge; hold = cycles spent in DONE before taking the result.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eh, input logic [31:0] el, input int hold,
                        input string tag);
    int cyc;
    check({tag, "/req_ready"}, req_ready, 1);
    req_valid = 1'b1; op = o; a_in = a; b_in = b;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check({tag, "/busy"}, {busy, req_ready}, 2'b10);
    cyc = 0;
    while (!resp_valid && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, "/latency"}, cyc, 34);
    check({tag, "/hi"}, hi_out, eh);
    check({tag, "/lo"}, lo_out, el);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({tag, "/hold"}, {resp_valid, req_ready, hi_out, lo_out}, {2'b10, eh, el});
    end
    resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    resp_ready = 1'b0;
    check({tag, "/released"}, {resp_valid, req_ready}, 2'b01);
  endtask

  task automatic run_op8(input logic [1:0] o, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] eh, input logic [7:0] el, input string tag);
    int cyc;
    req_valid_8 = 1'b1; op_8 = o; a_in_8 = a; b_in_8 = b;
    @(posedge clk);
    @(negedge clk);
    req_valid_8 = 1'b0;
    cyc = 0;
    while (!resp_valid_8 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, "/latency"}, cyc, 10);
    check({tag, "/hi"}, hi_out_8, eh);
    check({tag, "/lo"}, lo_out_8, el);
    resp_ready_8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    resp_ready_8 = 1'b0;
  endtask

  initial begin
    int cyc;
    logic seen;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset/state", {req_ready, resp_valid, busy, hi_out, lo_out}, {3'b100, 64'h0});
    rst = 1'b0;
    @(negedge clk);
    check("reset/after", {req_ready, resp_valid, busy}, 3'b100);

    run_op(OP_MULT,  32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFA, 0, "mult_neg");
    run_op(OP_MULTU, 32'hFFFFFFFE, 32'h00000003, 32'h00000002, 32'hFFFFFFFA, 0, "multu");
    run_op(OP_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 0, "div_neg");
    run_op(OP_DIVU,  32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003, 0, "divu");
    run_op(OP_DIVU,  32'h12345678, 32'h00000000, 32'h12345678, 32'hFFFFFFFF, 0, "divu_zero");
    run_op(OP_DIV,   32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF, 0, "div_zero");
    run_op(OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 0, "div_ovf");
    run_op(OP_DIV,   32'd100,      32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFF2, 0, "div_negb");
    run_op(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 10, "hold");
    run_op(OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 0, "back2back");

    // A request presented together with flush is dropped.
    req_valid = 1'b1; flush = 1'b1; op = OP_MULT; a_in = 32'd5; b_in = 32'd5;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0; flush = 1'b0;
    check("flush_req/idle", {req_ready, busy}, 2'b10);

    // Flush during CALC cycle 5.
    req_valid = 1'b1; op = OP_MULTU; a_in = 32'h1234; b_in = 32'h5678;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    for (cyc = 0; cyc < 5; cyc++) @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0;
    check("flush/idle", {req_ready, busy, resp_valid}, 3'b100);
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (resp_valid) seen = 1'b1;
    end
    check("flush/no_resp", seen, 0);

    // Reset during CALC cycle 12 of a fresh op.
    req_valid = 1'b1; op = OP_DIVU; a_in = 32'hDEADBEEF; b_in = 32'd3;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    for (cyc = 0; cyc < 12; cyc++) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst/outputs", {req_ready, resp_valid, busy, hi_out, lo_out}, {3'b100, 64'h0});

    run_op8(OP_MULT, 8'h80, 8'h80, 8'h40, 8'h00, "w8_mult");
    run_op8(OP_DIV,  8'h81, 8'h03, 8'hFF, 8'hD6, "w8_div");
    run_op8(OP_DIVU, 8'hFF, 8'h00, 8'hFF, 8'hFF, "w8_divu_zero");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
